// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory bus and grant signals shared by mem_bus_arbiter and its environment.
// master: arbiter view (it masters the memory bus); slave: requesters + memory view.
interface mem_bus_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  // Fetch requester (read-only)
  logic              f_req;
  logic [DATA_W-1:0] f_addr;
  logic              f_ack;
  logic              f_err;
  logic [DATA_W-1:0] f_rdata;
  // Data requester (read/write)
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  // Unified memory bus
  logic [1:0]        bus_cmd;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;
  logic              bus_wait;
  // Current or last grantee: 0 fetch, 1 data
  logic              owner;

  modport master (
    input  f_req, f_addr,
    output f_ack, f_err, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_err, d_rdata,
    output bus_cmd, bus_out, bus_oe,
    input  bus_in, bus_wait,
    output owner
  );

  modport slave (
    output f_req, f_addr,
    input  f_ack, f_err, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_err, d_rdata,
    input  bus_cmd, bus_out, bus_oe,
    output bus_in, bus_wait,
    input  owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one unified memory bus between the fetch unit and the
// load/store unit. Each transfer is an address phase followed by a data phase
// that memory may stretch with bus_wait; a watchdog aborts a data phase that
// stays stretched past WAIT_MAX cycles.
// Ties are round robin by default; define ARB_FETCH_PRIO_EN to make fetch win
// every tie (data is still served whenever fetch is not requesting).
module mem_bus_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_MAX = 7
) (
  input logic               CLK,
  input logic               RST,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              w_next_owner;
  logic              r_is_wr;
  logic              w_next_is_wr;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_next_wait_cnt;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_idle_gnt;
  logic              w_idle_gnt_d;
  logic              w_exit_gnt;
  logic              w_exit_gnt_d;

  cmd_t              w_cmd;
  logic [DATA_W-1:0] w_out;
  logic              w_oe;
  logic              w_done;
  logic              w_abort;

  // Arbitration decisions: a fresh pick in IDLE, and the hand-over pick taken
  // at the end of a data phase (the just-served requester is excluded there).
  always_comb begin
    w_idle_gnt   = bus.f_req | bus.d_req;
    w_idle_gnt_d = 1'b0;
    w_exit_gnt   = 1'b0;
    w_exit_gnt_d = 1'b0;
`ifdef ARB_FETCH_PRIO_EN
    w_idle_gnt_d = ~bus.f_req & bus.d_req;
    if (r_owner) begin
      w_exit_gnt   = bus.f_req;
      w_exit_gnt_d = 1'b0;
    end else begin
      // fetch still asking means a tie it would win; re-arbitrate from IDLE
      w_exit_gnt   = bus.d_req & ~bus.f_req;
      w_exit_gnt_d = 1'b1;
    end
`else
    if (bus.f_req && bus.d_req) begin
      w_idle_gnt_d = ~r_owner;
    end else begin
      w_idle_gnt_d = bus.d_req;
    end
    w_exit_gnt   = r_owner ? bus.f_req : bus.d_req;
    w_exit_gnt_d = ~r_owner;
`endif
  end

  // FSM next state, grant bookkeeping and bus drive
  always_comb begin
    w_next_state    = r_state;
    w_next_owner    = r_owner;
    w_next_is_wr    = r_is_wr;
    w_next_wait_cnt = r_wait_cnt;
    w_cmd           = CMD_NOP;
    w_out           = '0;
    w_oe            = 1'b0;
    w_done          = 1'b0;
    w_abort         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_idle_gnt) begin
          w_next_state = S_ADDR;
          w_next_owner = w_idle_gnt_d;
          w_next_is_wr = w_idle_gnt_d & bus.d_we;
        end
      end

      S_ADDR: begin
        w_cmd        = r_is_wr ? CMD_WRITE : CMD_READ;
        w_out        = r_owner ? bus.d_addr : bus.f_addr;
        w_oe         = 1'b1;
        w_next_state = S_DATA;
      end

      S_DATA: begin
        w_cmd = r_is_wr ? CMD_WRITE : CMD_READ;
        if (r_is_wr) begin
          w_out = bus.d_wdata;
          w_oe  = 1'b1;
        end
        if (!bus.bus_wait) begin
          w_done = 1'b1;
        end else if (r_wait_cnt == WAIT_LIM) begin
          w_abort = 1'b1;
        end else begin
          w_next_wait_cnt = r_wait_cnt + 8'd1;
        end
        if (w_done || w_abort) begin
          w_next_wait_cnt = '0;
          if (w_exit_gnt) begin
            w_next_state = S_ADDR;
            w_next_owner = w_exit_gnt_d;
            w_next_is_wr = w_exit_gnt_d & bus.d_we;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end

      default: begin
        w_next_state    = S_IDLE;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  // State, grantee and watchdog registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b1;
      r_is_wr    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_owner    <= w_next_owner;
      r_is_wr    <= w_next_is_wr;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Capture read data at the edge that closes a successful read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_done && !r_is_wr) begin
      if (r_owner) begin
        r_d_rdata <= bus.bus_in;
      end else begin
        r_f_rdata <= bus.bus_in;
      end
    end
  end

  assign bus.bus_cmd = w_cmd;
  assign bus.bus_out = w_out;
  assign bus.bus_oe  = w_oe;
  assign bus.owner   = r_owner;

  assign bus.f_ack   = w_done  & ~r_owner;
  assign bus.d_ack   = w_done  &  r_owner;
  assign bus.f_err   = w_abort & ~r_owner;
  assign bus.d_err   = w_abort &  r_owner;

  // rdata shows the bus value during the completing cycle, then the captured copy
  assign bus.f_rdata = (w_done && !r_is_wr && !r_owner) ? bus.bus_in : r_f_rdata;
  assign bus.d_rdata = (w_done && !r_is_wr &&  r_owner) ? bus.bus_in : r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// single-requester transfers checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WAIT_MAX = 7;

  logic CLK;
  logic RST;

  mem_bus_arbiter_if #(.DATA_W(DATA_W)) u_if ();

  mem_bus_arbiter #(
    .DATA_W  (DATA_W),
    .WAIT_MAX(WAIT_MAX)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .bus(u_if.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned total;
  int unsigned bad;
  logic [7:0]  m_frd;
  logic [7:0]  m_drd;

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs();
    u_if.f_req    = 1'b0;
    u_if.f_addr   = '0;
    u_if.d_req    = 1'b0;
    u_if.d_we     = 1'b0;
    u_if.d_addr   = '0;
    u_if.d_wdata  = '0;
    u_if.bus_in   = '0;
    u_if.bus_wait = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    m_frd = '0;
    m_drd = '0;
    step();
    step();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1'b0;
    m_frd = '0;
    m_drd = '0;
    step();
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe, u_if.bus_out} !== 11'h000) begin
      bad++;
      $display("FAIL reset_bus: cmd/oe/out=%h want 000", {u_if.bus_cmd, u_if.bus_oe, u_if.bus_out});
    end
    total++;
    if ({u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err, u_if.owner} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_flags: ack/err/owner=%b want 00001",
               {u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err, u_if.owner});
    end
    total++;
    if ({u_if.f_rdata, u_if.d_rdata} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rdata: f/d rdata=%h want 0000", {u_if.f_rdata, u_if.d_rdata});
    end
    step();
    RST = 1'b1;
  endtask

  // One transfer by a single requester, starting in an IDLE cycle and ending
  // in the IDLE cycle after completion. The model: the grantee completes in
  // the first data-phase cycle with bus_wait low, unless WAIT_MAX stretched
  // cycles have already passed, in which case it aborts on cycle WAIT_MAX.
  task automatic do_xfer(input bit is_d, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rd,
                         input int unsigned waits, input string tag);
    bit          abort;
    bit          wr;
    int unsigned last;
    logic [1:0]  ecmd;
    logic [7:0]  efrd;
    logic [7:0]  edrd;
    bit          eack;
    bit          eerr;
    abort = (waits > WAIT_MAX);
    last  = abort ? WAIT_MAX : waits;
    wr    = is_d && we;
    ecmd  = wr ? 2'b10 : 2'b01;

    if (is_d) begin
      u_if.d_req = 1'b1; u_if.d_we = we; u_if.d_addr = addr; u_if.d_wdata = wdata;
    end else begin
      u_if.f_req = 1'b1; u_if.f_addr = addr;
    end
    u_if.bus_wait = 1'b0;
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe} !== 3'b000) begin
      bad++;
      $display("FAIL %s idle: cmd/oe=%b want 000", tag, {u_if.bus_cmd, u_if.bus_oe});
    end
    step();
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe, u_if.bus_out, u_if.owner} !== {ecmd, 1'b1, addr, is_d}) begin
      bad++;
      $display("FAIL %s addr: cmd/oe/out/owner=%b/%b/%h/%b want %b/1/%h/%b", tag,
               u_if.bus_cmd, u_if.bus_oe, u_if.bus_out, u_if.owner, ecmd, addr, is_d);
    end
    for (int unsigned i = 0; i <= last; i++) begin
      step();
      u_if.bus_wait = (i < waits);
      u_if.bus_in   = (i == last) ? rd : 8'($urandom);
      #1;
      eack = (i == last) && !abort;
      eerr = (i == last) && abort;
      efrd = (eack && !is_d) ? rd : m_frd;
      edrd = (eack && is_d && !we) ? rd : m_drd;
      total++;
      if ({u_if.bus_cmd, u_if.bus_oe} !== {ecmd, wr}) begin
        bad++;
        $display("FAIL %s data%0d cmd/oe=%b want %b", tag, i, {u_if.bus_cmd, u_if.bus_oe}, {ecmd, wr});
      end
      if (wr) begin
        total++;
        if (u_if.bus_out !== wdata) begin
          bad++;
          $display("FAIL %s data%0d bus_out=%h want %h", tag, i, u_if.bus_out, wdata);
        end
      end
      total++;
      if ({u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err} !==
          {eack && !is_d, eack && is_d, eerr && !is_d, eerr && is_d}) begin
        bad++;
        $display("FAIL %s data%0d fack/dack/ferr/derr=%b want %b", tag, i,
                 {u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err},
                 {eack && !is_d, eack && is_d, eerr && !is_d, eerr && is_d});
      end
      total++;
      if ({u_if.f_rdata, u_if.d_rdata} !== {efrd, edrd}) begin
        bad++;
        $display("FAIL %s data%0d f/d rdata=%h/%h want %h/%h", tag, i,
                 u_if.f_rdata, u_if.d_rdata, efrd, edrd);
      end
    end
    if (!abort && !is_d) m_frd = rd;
    if (!abort && is_d && !we) m_drd = rd;
    step();
    u_if.f_req = 1'b0;
    u_if.d_req = 1'b0;
    u_if.bus_wait = 1'b0;
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe, u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err} !== 7'b0) begin
      bad++;
      $display("FAIL %s after: cmd/oe/flags=%b want 0000000", tag,
               {u_if.bus_cmd, u_if.bus_oe, u_if.f_ack, u_if.d_ack, u_if.f_err, u_if.d_err});
    end
    total++;
    if ({u_if.f_rdata, u_if.d_rdata} !== {m_frd, m_drd}) begin
      bad++;
      $display("FAIL %s hold: f/d rdata=%h/%h want %h/%h", tag, u_if.f_rdata, u_if.d_rdata, m_frd, m_drd);
    end
  endtask

  task automatic test_fetch_read();
    do_xfer(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 0, "fetch_read");
  endtask

  task automatic test_data_write();
    do_xfer(1'b1, 1'b1, 8'h20, 8'h3C, 8'h5A, 0, "data_write");
  endtask

  task automatic test_wait();
    do_xfer(1'b1, 1'b0, 8'h44, 8'h00, 8'h77, 3, "wait3");
    do_xfer(1'b0, 1'b0, 8'h45, 8'h00, 8'h19, WAIT_MAX, "wait_max");
  endtask

  task automatic test_watchdog();
    do_xfer(1'b1, 1'b0, 8'h66, 8'h00, 8'hEE, 50, "watchdog");
    do_xfer(1'b1, 1'b1, 8'h67, 8'hC3, 8'h00, WAIT_MAX + 1, "watchdog_wr");
  endtask

  task automatic test_random();
    bit          is_d;
    bit          we;
    int unsigned waits;
    for (int k = 0; k < 30; k++) begin
      is_d  = 1'($urandom_range(0, 1));
      we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      waits = $urandom_range(0, WAIT_MAX + 2);
      do_xfer(is_d, we, 8'($urandom), 8'($urandom), 8'($urandom), waits, "rand");
    end
  endtask

  // Both requesters held high from reset. Round robin: transfers alternate
  // F,D,F,... every 2 cycles with no IDLE. Fetch priority: F every 3 cycles.
  task automatic test_back_to_back();
    int unsigned n;
    int unsigned p;
    logic [1:0]  ecmd;
    bit          efa;
    bit          eda;
    bit          eown;
    apply_reset();
    u_if.f_req = 1'b1; u_if.f_addr = 8'h81;
    u_if.d_req = 1'b1; u_if.d_we = 1'b0; u_if.d_addr = 8'h82;
    u_if.bus_wait = 1'b0;
    #1;
    total++;
    if (u_if.bus_cmd !== 2'b00) begin
      bad++;
      $display("FAIL b2b idle: cmd=%b want 00", u_if.bus_cmd);
    end
    for (int unsigned c = 1; c <= 12; c++) begin
      step();
      u_if.bus_in = 8'($urandom);
      #1;
`ifdef ARB_FETCH_PRIO_EN
      p    = (c - 1) % 3;
      n    = 0;
      ecmd = (p == 2) ? 2'b00 : 2'b01;
      efa  = (p == 1);
      eda  = 1'b0;
      eown = 1'b0;
`else
      p    = (c - 1) % 2;
      n    = (c - 1) / 2;
      ecmd = 2'b01;
      efa  = (p == 1) && (n % 2 == 0);
      eda  = (p == 1) && (n % 2 == 1);
      eown = (n % 2 == 1);
`endif
      total++;
      if ({u_if.bus_cmd, u_if.f_ack, u_if.d_ack, u_if.owner} !== {ecmd, efa, eda, eown}) begin
        bad++;
        $display("FAIL b2b c%0d: cmd/fack/dack/owner=%b/%b/%b/%b want %b/%b/%b/%b", c,
                 u_if.bus_cmd, u_if.f_ack, u_if.d_ack, u_if.owner, ecmd, efa, eda, eown);
      end
    end
    clear_inputs();
    apply_reset();
  endtask

  task automatic test_reset_mid();
    u_if.d_req = 1'b1; u_if.d_we = 1'b1; u_if.d_addr = 8'h5E; u_if.d_wdata = 8'h9B;
    u_if.bus_wait = 1'b0;
    step();
    step();
    u_if.bus_wait = 1'b1;
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe} !== 3'b101) begin
      bad++;
      $display("FAIL rstmid pre: cmd/oe=%b want 101", {u_if.bus_cmd, u_if.bus_oe});
    end
    RST = 1'b0;
    m_frd = '0;
    m_drd = '0;
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe, u_if.d_ack, u_if.d_err} !== 5'b0) begin
      bad++;
      $display("FAIL rstmid during: cmd/oe/dack/derr=%b want 00000",
               {u_if.bus_cmd, u_if.bus_oe, u_if.d_ack, u_if.d_err});
    end
    step();
    step();
    RST = 1'b1;
    u_if.bus_wait = 1'b0;
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.d_ack, u_if.owner} !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid idle: cmd/dack/owner=%b want 0001", {u_if.bus_cmd, u_if.d_ack, u_if.owner});
    end
    step();
    #1;
    total++;
    if ({u_if.bus_cmd, u_if.bus_oe, u_if.bus_out} !== {2'b10, 1'b1, 8'h5E}) begin
      bad++;
      $display("FAIL rstmid addr: cmd/oe/out=%b/%b/%h want 10/1/5e", u_if.bus_cmd, u_if.bus_oe, u_if.bus_out);
    end
    step();
    #1;
    total++;
    if ({u_if.d_ack, u_if.bus_oe, u_if.bus_out, u_if.d_rdata} !== {1'b1, 1'b1, 8'h9B, 8'h00}) begin
      bad++;
      $display("FAIL rstmid data: dack/oe/out/drd=%b/%b/%h/%h want 1/1/9b/00",
               u_if.d_ack, u_if.bus_oe, u_if.bus_out, u_if.d_rdata);
    end
    step();
    u_if.d_req = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_wait();
    test_watchdog();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
